// File: rtl/seq_gen.sv
// Serial pattern generator: shifts a captured pattern out MSB-first, with an
// optional repeat count, a one-cycle idle gap between repeats and a done pulse.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// SHIFT | driving one pattern bit per clock
// GAP   | single idle cycle between repetitions
// DONE  | one-cycle done pulse, then back to IDLE
module seq_gen #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4,
  localparam int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  output logic             serOut,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] pat_q;
  logic [LEN_W-1:0] bit_cnt;
  logic [LEN_W-1:0] len_q;
  logic [REP_W-1:0] rep_cnt;

  logic [LEN_W-1:0] len_sat;
  logic [WIDTH-1:0] aligned;
  logic [REP_W-1:0] reps_eff;

  // Left-align the pattern so bit len-1 sits in the MSB of the shift register.
  always_comb begin
    len_sat  = (int'(len) > WIDTH) ? LEN_W'(WIDTH) : len;
    aligned  = data_in << (WIDTH - int'(len_sat));
    reps_eff = (reps == '0) ? REP_W'(1) : reps;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      pat_q   <= '0;
      bit_cnt <= '0;
      len_q   <= '0;
      rep_cnt <= '0;
      serOut  <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          serOut <= 1'b0;
          valid  <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
          if (start) begin
            if (len_sat != '0) begin
              shreg   <= aligned;
              pat_q   <= aligned;
              bit_cnt <= len_sat;
              len_q   <= len_sat;
              rep_cnt <= reps_eff;
              state   <= SHIFT;
            end else begin
              state <= DONE;
            end
          end
        end

        SHIFT: begin
          serOut <= shreg[WIDTH-1];
          valid  <= 1'b1;
          busy   <= 1'b1;
          // Reload happens at count 1, so neither counter ever wraps.
          if (bit_cnt == LEN_W'(1)) begin
            if (rep_cnt > REP_W'(1)) begin
              rep_cnt <= rep_cnt - REP_W'(1);
              shreg   <= pat_q;
              bit_cnt <= len_q;
              state   <= GAP;
            end else begin
              shreg   <= '0;
              bit_cnt <= '0;
              state   <= DONE;
            end
          end else begin
            shreg   <= {shreg[WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt - LEN_W'(1);
          end
        end

        GAP: begin
          serOut <= 1'b0;
          valid  <= 1'b0;
          busy   <= 1'b1;
          state  <= SHIFT;
        end

        DONE: begin
          serOut  <= 1'b0;
          valid   <= 1'b0;
          busy    <= 1'b1;
          done    <= 1'b1;
          rep_cnt <= '0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: fixed vector table, reset/abort sequence, and randomized
// transfers compared against a cycle-list reference model.
module tb_seq_gen;

  localparam int WIDTH = 8;
  localparam int REP_W = 4;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [LEN_W-1:0] len = '0;
  logic [REP_W-1:0] reps = '0;
  logic             serOut, valid, busy, done;

  seq_gen #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .len(len),
    .reps(reps), .serOut(serOut), .valid(valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Expected observation per cycle after the accepting edge: {serOut, valid, busy, done}
  logic [3:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    int         l;
    int         r;
    string      seq;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input int idx, input logic [3:0] got,
                       input logic [3:0] want);
    n_total++;
    if (got !== want)
      $display("FAIL %s cyc %0d: got {ser,val,busy,done}=%b want %b", name, idx, got, want);
    else
      n_pass++;
  endtask

  function automatic logic [3:0] code(input byte c);
    case (c)
      "0":     return 4'b0110;
      "1":     return 4'b1110;
      "-":     return 4'b0010;
      "d":     return 4'b0011;
      default: return 4'b0000;
    endcase
  endfunction

  // Reference: list every output cycle of the transfer, then the idle cycle.
  function automatic void build_model(input logic [7:0] d, input int l, input int r);
    int le = (l > WIDTH) ? WIDTH : l;
    int re = (r == 0) ? 1 : r;
    exp_q.delete();
    if (le > 0) begin
      for (int k = 0; k < re; k++) begin
        for (int i = le - 1; i >= 0; i--) exp_q.push_back({d[i], 3'b110});
        if (k < re - 1) exp_q.push_back(4'b0010);
      end
    end
    exp_q.push_back(4'b0011);
    exp_q.push_back(4'b0000);
  endfunction

  function automatic void build_from_string(input string s);
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(code(s[i]));
    exp_q.push_back(4'b0000);
  endfunction

  task automatic apply(input logic [7:0] d, input int l, input int r, input bit disturb,
                       input string name);
    @(negedge clk);
    data_in = d;
    len     = LEN_W'(l);
    reps    = REP_W'(r);
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int j = 0; j < exp_q.size(); j++) begin
      if (disturb && j < exp_q.size() - 1) begin
        start   = 1'($urandom_range(0, 1));
        data_in = 8'($urandom);
        len     = LEN_W'($urandom);
        reps    = REP_W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      check(name, j, {serOut, valid, busy, done}, exp_q[j]);
    end
    start = 1'b0;
  endtask

  initial begin
    tbl[0] = '{8'h3E, 8,  1, "00111110d"};
    tbl[1] = '{8'h07, 4,  3, "0111-0111-0111d"};
    tbl[2] = '{8'hFF, 0,  5, "d"};
    tbl[3] = '{8'h05, 3,  0, "101d"};
    tbl[4] = '{8'hA5, 15, 2, "10100101-10100101d"};
    tbl[5] = '{8'h81, 1,  2, "1-1d"};
    tbl[6] = '{8'hC3, 5,  1, "00011d"};

    #2 rst = 1'b0;
    #1 check("reset", 0, {serOut, valid, busy, done}, 4'b0000);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("idle_no_start", 0, {serOut, valid, busy, done}, 4'b0000);

    foreach (tbl[t]) begin
      build_from_string(tbl[t].seq);
      apply(tbl[t].data, tbl[t].l, tbl[t].r, 1'b0, $sformatf("table%0d", t));
    end

    // Restart with start/data_in toggling mid-transfer: must not disturb the output.
    build_from_string(tbl[0].seq);
    apply(tbl[0].data, tbl[0].l, tbl[0].r, 1'b1, "start_ignored");
    build_from_string(tbl[1].seq);
    apply(tbl[1].data, tbl[1].l, tbl[1].r, 1'b1, "start_ignored_rep");

    // Abort with reset during the third bit, then a clean resend.
    @(negedge clk);
    data_in = 8'hE5; len = 4'd8; reps = 4'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("third_bit", 3, {serOut, valid, busy, done}, 4'b1110);
    #2 rst = 1'b0;
    #1 check("async_abort", 0, {serOut, valid, busy, done}, 4'b0000);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("after_abort_idle", 0, {serOut, valid, busy, done}, 4'b0000);
    build_model(8'hE5, 8, 1);
    apply(8'hE5, 8, 1, 1'b0, "resend");

    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      int l, r;
      d = 8'($urandom);
      l = $urandom_range(0, 15);
      r = $urandom_range(0, 15);
      build_model(d, l, r);
      apply(d, l, r, 1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
